// File: rtl/microwave_timer_ctrl_pkg.sv
// Shared types for the microwave cook timer: FSM states, mm:ss pair and the
// keypad-to-time normalisation used for both display and count load.
package microwave_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int SEC_MAX = 59;

  typedef struct packed {
    logic [5:0] m;
    logic [5:0] s;
  } mmss_t;

  // Digits are m = d3 d2, s = d1 d0; seconds overflow carries into minutes,
  // anything past max_min clamps to max_min:59.
  function automatic mmss_t normalise_time(input logic [3:0] d3, input logic [3:0] d2,
                                           input logic [3:0] d1, input logic [3:0] d0,
                                           input int max_min);
    int    m;
    int    s;
    mmss_t r;
    m = 10 * int'(d3) + int'(d2);
    s = 10 * int'(d1) + int'(d0);
    if (s > SEC_MAX) begin
      s = s - 60;
      m = m + 1;
    end
    if (m > max_min) begin
      m = max_min;
      s = SEC_MAX;
    end
    r.m = m[5:0];
    r.s = s[5:0];
    return r;
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_if.sv
// Keypad/control strobes in, display and status out. The controller sits on
// the slave side; whoever drives the keypad uses master.
interface microwave_timer_ctrl_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       pause;
  logic       cancel;
  logic       door_open;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       done;
  logic       beep;

  modport master (
    output key_valid, key_digit, start, pause, cancel, door_open,
    input  minutes, seconds, running, done, beep
  );

  modport slave (
    input  key_valid, key_digit, start, pause, cancel, door_open,
    output minutes, seconds, running, done, beep
  );
endinterface

// File: rtl/microwave_timer_ctrl_tick_gen.sv
// One-second prescaler: counts enabled cycles 0..CLK_HZ-1 and pulses tick on
// the wrap cycle. Holding en low freezes the phase so a pause resumes mid-second.
module microwave_timer_ctrl_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) pre <= '0;
    else if (en)       pre <= (pre == LAST) ? '0 : pre + 1'b1;
  end

  assign tick = en && (pre == LAST);
endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook timer: keypad entry buffer, mm:ss down-counter driven by a
// 1 s tick, pause/door/cancel handling and a timed completion beep.
module microwave_timer_ctrl
  import microwave_timer_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int MAX_MIN   = 59,
  parameter int BEEP_SECS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  microwave_timer_ctrl_if.slave bus
);
  localparam int BW = (BEEP_SECS > 0) ? $clog2(BEEP_SECS + 1) : 1;

  state_t          state, state_n;
  logic [3:0][3:0] dig;
  mmss_t           entry_t;
  logic [5:0]      min_q, sec_q;
  logic [BW-1:0]   beep_cnt;
  logic            key_ok, tick, tick_en, load, shift;
  logic            cnt_last, beep_last;
  logic            running_d, done_d, beep_d;
  logic            running_q, done_q, beep_q;

  assign key_ok    = bus.key_valid && (bus.key_digit <= 4'd9);
  assign entry_t   = normalise_time(dig[3], dig[2], dig[1], dig[0], MAX_MIN);
  assign cnt_last  = (min_q == 6'd0) && (sec_q == 6'd1);
  assign beep_last = (beep_cnt == BW'(BEEP_SECS - 1));

  // A tick landing on a pause/door/cancel cycle is dropped by keeping the
  // prescaler disabled, which also freezes its phase for the resume.
  assign tick_en = ((state == ST_RUN) && !bus.cancel && !bus.door_open && !bus.pause) ||
                   (state == ST_DONE);

  microwave_timer_ctrl_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (load || bus.cancel),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    shift   = 1'b0;
    if (bus.cancel) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_ENTRY: begin
          if (bus.start) begin
            if ((state == ST_ENTRY) && !bus.door_open && (entry_t != '0)) begin
              state_n = ST_RUN;
              load    = 1'b1;
            end
          end else if (key_ok) begin
            state_n = ST_ENTRY;
            shift   = 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.door_open || bus.pause) state_n = ST_PAUSED;
          else if (tick && cnt_last)      state_n = ST_DONE;
        end
        ST_PAUSED: begin
          if (bus.start && !bus.door_open && !bus.pause) state_n = ST_RUN;
        end
        ST_DONE: begin
          if (bus.start || key_ok || (tick && beep_last)) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    running_d = (state_n == ST_RUN);
    done_d    = (state_n == ST_DONE);
    beep_d    = (state_n == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
      beep_q    <= 1'b0;
    end else begin
      running_q <= running_d;
      done_q    <= done_d;
      beep_q    <= beep_d;
    end
  end

  // Entry buffer is consumed by the count load and wiped whenever we fall back to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n || load || (state_n == ST_IDLE)) dig <= '0;
    else if (shift)                             dig <= {dig[2:0], bus.key_digit};
  end

  // min_q/sec_q double as the entry display and the running count.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.cancel) begin
      min_q <= '0;
      sec_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_ENTRY: begin
          min_q <= entry_t.m;
          sec_q <= entry_t.s;
        end
        ST_RUN: begin
          if (tick) begin
            if (sec_q != 6'd0) begin
              sec_q <= sec_q - 6'd1;
            end else begin
              min_q <= min_q - 6'd1;
              sec_q <= 6'(SEC_MAX);
            end
          end
        end
        ST_PAUSED: ;
        ST_DONE: begin
          min_q <= '0;
          sec_q <= '0;
        end
        default: begin
          min_q <= '0;
          sec_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (state != ST_DONE)) beep_cnt <= '0;
    else if (tick)                    beep_cnt <= beep_cnt + 1'b1;
  end

  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.beep    = beep_q;
endmodule
